// File: rtl/hwacc_tcdm_port_arbiter.sv
// hwacc_tcdm_port_arbiter
// Shares N_HWACC accelerators, each with N_PORTS TCDM master ports, onto
// N_PORTS shared cluster TCDM ports. Shared port p is arbitrated among port p
// of every accelerator, either round-robin or by a single static owner, and
// the one-cycle-latency response is steered back to whoever won the grant.

module hwacc_tcdm_port_arbiter #(
    parameter int N_HWACC = 3,
    parameter int N_PORTS = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int CNT_W   = 16,
    localparam int BW     = DW / 8,
    localparam int SW     = (N_HWACC > 1) ? $clog2(N_HWACC) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic                           cfg_mode_i,
    input  logic [SW-1:0]                  cfg_sel_i,
    input  logic [N_HWACC-1:0]             cfg_en_i,

    input  logic [N_HWACC*N_PORTS-1:0]     acc_req_i,
    output logic [N_HWACC*N_PORTS-1:0]     acc_gnt_o,
    input  logic [N_HWACC*N_PORTS*AW-1:0]  acc_add_i,
    input  logic [N_HWACC*N_PORTS-1:0]     acc_wen_i,
    input  logic [N_HWACC*N_PORTS*BW-1:0]  acc_be_i,
    input  logic [N_HWACC*N_PORTS*DW-1:0]  acc_data_i,
    output logic [N_HWACC*N_PORTS*DW-1:0]  acc_r_data_o,
    output logic [N_HWACC*N_PORTS-1:0]     acc_r_valid_o,

    output logic [N_PORTS-1:0]             tcdm_req_o,
    input  logic [N_PORTS-1:0]             tcdm_gnt_i,
    output logic [N_PORTS*AW-1:0]          tcdm_add_o,
    output logic [N_PORTS-1:0]             tcdm_wen_o,
    output logic [N_PORTS*BW-1:0]          tcdm_be_o,
    output logic [N_PORTS*DW-1:0]          tcdm_data_o,
    input  logic [N_PORTS*DW-1:0]          tcdm_r_data_i,
    input  logic [N_PORTS-1:0]             tcdm_r_valid_i,

    output logic [N_HWACC*CNT_W-1:0]       stall_cnt_o,
    output logic                           err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Configuration shadow: the arbiter only ever looks at these copies
    logic                 cfgMode_q, cfgMode_d;
    logic [SW-1:0]        cfgSel_q, cfgSel_d;
    logic [N_HWACC-1:0]   cfgEn_q, cfgEn_d;

    // Per shared port arbitration and response tracking state
    logic [SW-1:0]        rrPtr_q [N_PORTS];
    logic [SW-1:0]        rrPtr_d [N_PORTS];
    logic [SW-1:0]        owner_q [N_PORTS];
    logic [SW-1:0]        owner_d [N_PORTS];
    logic [N_PORTS-1:0]   pending_q, pending_d;

    // Per accelerator stall counters and the sticky error flag
    logic [CNT_W-1:0]     stallCnt_q [N_HWACC];
    logic [CNT_W-1:0]     stallCnt_d [N_HWACC];
    logic                 err_q, err_d;

    // Combinational arbitration results
    logic [N_HWACC-1:0]   eligible [N_PORTS];
    logic [SW-1:0]        winner   [N_PORTS];
    logic [N_PORTS-1:0]   anyReq;
    logic [N_PORTS-1:0]   grant;
    logic [N_HWACC-1:0]   stallHit;
    logic                 cfgIdle;

    // Pointer advance that wraps at N_HWACC rather than at 2**SW
    function automatic logic [SW-1:0] incWrap(input logic [SW-1:0] v);
        if (int'(v) >= N_HWACC - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Work out which accelerators may compete on each shared port this cycle
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            eligible[p] = '0;
            for (int a = 0; a < N_HWACC; a++) begin
                eligible[p][a] = acc_req_i[a*N_PORTS+p] & cfgEn_q[a] &
                                 (~cfgMode_q | (cfgSel_q == SW'(a)));
            end
        end
    end

    // Round-robin search starting at each port's pointer; in static mode only
    // the owner is eligible, so the same search simply finds it
    always_comb begin
        int cand;
        cand = 0;
        for (int p = 0; p < N_PORTS; p++) begin
            winner[p] = '0;
            anyReq[p] = 1'b0;
            for (int i = 0; i < N_HWACC; i++) begin
                cand = (int'(rrPtr_q[p]) + i) % N_HWACC;
                if (!anyReq[p] && eligible[p][cand]) begin
                    winner[p] = SW'(cand);
                    anyReq[p] = 1'b1;
                end
            end
        end
    end

    assign grant      = anyReq & tcdm_gnt_i;
    assign tcdm_req_o = anyReq;

    // Forward the winner's request fields to the shared port and hand the
    // shared grant back to the winner only
    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = '0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        acc_gnt_o   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int a = 0; a < N_HWACC; a++) begin
                if (anyReq[p] && (winner[p] == SW'(a))) begin
                    tcdm_add_o[p*AW +: AW]  = acc_add_i[(a*N_PORTS+p)*AW +: AW];
                    tcdm_wen_o[p]           = acc_wen_i[a*N_PORTS+p];
                    tcdm_be_o[p*BW +: BW]   = acc_be_i[(a*N_PORTS+p)*BW +: BW];
                    tcdm_data_o[p*DW +: DW] = acc_data_i[(a*N_PORTS+p)*DW +: DW];
                    acc_gnt_o[a*N_PORTS+p]  = tcdm_gnt_i[p];
                end
            end
        end
    end

    // Steer each shared response to the accelerator granted one cycle earlier
    always_comb begin
        acc_r_valid_o = '0;
        acc_r_data_o  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int a = 0; a < N_HWACC; a++) begin
                if (pending_q[p] && (owner_q[p] == SW'(a))) begin
                    acc_r_valid_o[a*N_PORTS+p]       = tcdm_r_valid_i[p];
                    acc_r_data_o[(a*N_PORTS+p)*DW +: DW] = tcdm_r_data_i[p*DW +: DW];
                end
            end
        end
    end

    // An enabled accelerator stalls when any of its requests went ungranted
    always_comb begin
        stallHit = '0;
        for (int a = 0; a < N_HWACC; a++) begin
            stallHit[a] = cfgEn_q[a] &
                          (|(acc_req_i[a*N_PORTS +: N_PORTS] &
                             ~acc_gnt_o[a*N_PORTS +: N_PORTS]));
        end
    end

    // Config may only change when no transaction is granted or in flight
    assign cfgIdle = ~(|pending_q) & ~(|grant);

    // Next-state logic for all registered state
    always_comb begin
        cfgMode_d = cfgMode_q;
        cfgSel_d  = cfgSel_q;
        cfgEn_d   = cfgEn_q;
        if (cfgIdle) begin
            cfgMode_d = cfg_mode_i;
            cfgSel_d  = cfg_sel_i;
            cfgEn_d   = cfg_en_i;
        end

        pending_d = grant;
        for (int p = 0; p < N_PORTS; p++) begin
            rrPtr_d[p] = rrPtr_q[p];
            owner_d[p] = owner_q[p];
            if (grant[p]) begin
                rrPtr_d[p] = incWrap(winner[p]);
                owner_d[p] = winner[p];
            end
        end

        for (int a = 0; a < N_HWACC; a++) begin
            stallCnt_d[a] = stallCnt_q[a];
            if (stallHit[a] && (stallCnt_q[a] != CNT_MAX)) begin
                stallCnt_d[a] = stallCnt_q[a] + 1'b1;
            end
        end

        err_d = err_q | (|(tcdm_r_valid_i & ~pending_q));
    end

    // Config shadow register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfgMode_q <= 1'b0;
            cfgSel_q  <= '0;
            cfgEn_q   <= '0;
        end else begin
            cfgMode_q <= cfgMode_d;
            cfgSel_q  <= cfgSel_d;
            cfgEn_q   <= cfgEn_d;
        end
    end

    // Round-robin pointers, response owners and pending flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            for (int p = 0; p < N_PORTS; p++) begin
                rrPtr_q[p] <= '0;
                owner_q[p] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int p = 0; p < N_PORTS; p++) begin
                rrPtr_q[p] <= rrPtr_d[p];
                owner_q[p] <= owner_d[p];
            end
        end
    end

    // Saturating stall counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int a = 0; a < N_HWACC; a++) begin
                stallCnt_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < N_HWACC; a++) begin
                stallCnt_q[a] <= stallCnt_d[a];
            end
        end
    end

    // Sticky flag for responses that nobody was waiting for
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        stall_cnt_o = '0;
        for (int a = 0; a < N_HWACC; a++) begin
            stall_cnt_o[a*CNT_W +: CNT_W] = stallCnt_q[a];
        end
    end

    assign err_o = err_q;

endmodule
